// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared definitions for the UART command sequencer: FSM states, ASCII codes
// and the command-strobe index map.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      ACK,
      ARG,
      ARG_DONE,
      ERR,
      STAT
   } state_t;

   localparam logic [7:0] ASC_R    = 8'h52;
   localparam logic [7:0] ASC_V    = 8'h56;
   localparam logic [7:0] ASC_A    = 8'h41;
   localparam logic [7:0] ASC_STAR = 8'h2A;
   localparam logic [7:0] ASC_BANG = 8'h21;
   localparam logic [7:0] ASC_0    = 8'h30;
   localparam logic [7:0] ASC_1    = 8'h31;

   localparam int unsigned N_STROBES = 13;
   localparam int unsigned STB_D  = 0;
   localparam int unsigned STB_DL = 1;
   localparam int unsigned STB_C  = 2;
   localparam int unsigned STB_E  = 3;
   localparam int unsigned STB_EL = 4;
   localparam int unsigned STB_O  = 5;
   localparam int unsigned STB_OL = 6;
   localparam int unsigned STB_S  = 7;
   localparam int unsigned STB_T  = 8;
   localparam int unsigned STB_TL = 9;
   localparam int unsigned STB_U  = 10;
   localparam int unsigned STB_W  = 11;
   localparam int unsigned STB_X  = 12;

   // One-hot strobe for a mapped command character, all-zero otherwise.
   function automatic logic [N_STROBES-1:0] strobe_decode(input logic [7:0] c);
      logic [N_STROBES-1:0] v;
      v = '0;
      case (c)
         8'h44:   v[STB_D]  = 1'b1;
         8'h64:   v[STB_DL] = 1'b1;
         8'h43:   v[STB_C]  = 1'b1;
         8'h45:   v[STB_E]  = 1'b1;
         8'h65:   v[STB_EL] = 1'b1;
         8'h4F:   v[STB_O]  = 1'b1;
         8'h6F:   v[STB_OL] = 1'b1;
         8'h53:   v[STB_S]  = 1'b1;
         8'h54:   v[STB_T]  = 1'b1;
         8'h74:   v[STB_TL] = 1'b1;
         8'h55:   v[STB_U]  = 1'b1;
         8'h57:   v[STB_W]  = 1'b1;
         8'h58:   v[STB_X]  = 1'b1;
         default: ;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Character, status and transmit signals between the UART side (master) and
// the command sequencer (slave).
interface uart_cmd_sequencer_if #(
   parameter int unsigned ARG_BITS = 10,
   parameter int unsigned STAT_CH  = 1
);
   logic [7:0]                       Cmd;
   logic                             NewCmd;
   logic                             echoChar;
   logic [4*STAT_CH-1:0]             status;
   logic                             txReady;
   logic [uart_cmd_pkg::N_STROBES-1:0] cmdStrobe;
   logic [ARG_BITS-1:0]              argValue;
   logic                             argValid;
   logic                             argError;
   logic [7:0]                       txData;
   logic                             txDataWr;

   modport master (
      output Cmd, NewCmd, echoChar, status, txReady,
      input  cmdStrobe, argValue, argValid, argError, txData, txDataWr
   );

   modport slave (
      input  Cmd, NewCmd, echoChar, status, txReady,
      output cmdStrobe, argValue, argValid, argError, txData, txDataWr
   );
endinterface

// File: rtl/uart_cmd_sequencer_arg_shift_reg.sv
// Argument collector: MSB-first shift register, bit counter and inter-character
// timeout for the 'V' command.
module arg_shift_reg
   import uart_cmd_pkg::*;
#(
   parameter int unsigned ARG_BITS    = 10,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_clear,
   input  logic                i_active,
   input  logic                i_new,
   input  logic [7:0]          i_cmd,
   output logic                o_done,
   output logic                o_bad,
   output logic                o_timeout,
   output logic [ARG_BITS-1:0] o_value
);
   localparam int unsigned BIT_W = $clog2(ARG_BITS + 1);
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [ARG_BITS-1:0] r_shift;
   logic [BIT_W-1:0]    r_bits;
   logic [CNT_W-1:0]    r_idle;
   logic                w_is_bit;
   logic                w_shift;

   assign w_is_bit  = (i_cmd == ASC_0) || (i_cmd == ASC_1);
   assign w_shift   = i_active && i_new && w_is_bit;
   assign o_value   = (r_shift << 1) | ARG_BITS'(i_cmd == ASC_1);
   assign o_done    = w_shift && (r_bits == BIT_W'(ARG_BITS - 1));
   assign o_bad     = i_active && i_new && !w_is_bit && (i_cmd != ASC_R);
   // Fires on the edge where the idle count steps to TIMEOUT_CYC-1.
   assign o_timeout = i_active && !i_new && (r_idle == CNT_W'(TIMEOUT_CYC - 2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_bits  <= '0;
         r_idle  <= '0;
      end else if (i_clear) begin
         r_shift <= '0;
         r_bits  <= '0;
         r_idle  <= '0;
      end else if (i_active) begin
         if (i_new) r_idle <= '0;
         else       r_idle <= r_idle + 1'b1;
         if (w_shift) begin
            r_shift <= o_value;
            r_bits  <= r_bits + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Command sequencer: decodes UART characters into strobes, binary arguments and
// status/acknowledge bytes on a ready-gated transmit port.
module uart_cmd_sequencer
   import uart_cmd_pkg::*;
#(
   parameter int unsigned ARG_BITS    = 10,
   parameter int unsigned STAT_CH     = 1,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input logic                 clk,
   input logic                 rst,
   uart_cmd_sequencer_if.slave bus
);
   localparam int unsigned CH_W = (STAT_CH > 1) ? $clog2(STAT_CH) : 1;

   state_t               r_state;
   logic [N_STROBES-1:0] r_strobe;
   logic [ARG_BITS-1:0]  r_arg_value;
   logic                 r_arg_valid;
   logic                 r_arg_error;
   logic [7:0]           r_tx_data;
   logic                 r_tx_wr;
   logic [CH_W-1:0]      r_ch;

   logic                 w_echo, w_slot, w_abort, w_arg_start;
   logic                 w_arg_done, w_arg_bad, w_arg_timeout;
   logic [ARG_BITS-1:0]  w_arg_word;
   logic [N_STROBES-1:0] w_decode;
   logic [3:0]           w_nibble;

   assign w_echo      = bus.echoChar && bus.NewCmd && bus.txReady;
   assign w_slot      = bus.txReady && !w_echo;
   assign w_abort     = bus.NewCmd && (bus.Cmd == ASC_R);
   assign w_arg_start = (r_state == IDLE) && bus.NewCmd && (bus.Cmd == ASC_V);
   assign w_decode    = strobe_decode(bus.Cmd);
   assign w_nibble    = 4'(bus.status >> {r_ch, 2'b00});

   arg_shift_reg #(
      .ARG_BITS    (ARG_BITS),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_arg (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_arg_start),
      .i_active  (r_state == ARG),
      .i_new     (bus.NewCmd),
      .i_cmd     (bus.Cmd),
      .o_done    (w_arg_done),
      .o_bad     (w_arg_bad),
      .o_timeout (w_arg_timeout),
      .o_value   (w_arg_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_strobe    <= '0;
         r_arg_value <= '0;
         r_arg_valid <= 1'b0;
         r_arg_error <= 1'b0;
         r_tx_data   <= '0;
         r_tx_wr     <= 1'b0;
         r_ch        <= '0;
      end else begin
         r_strobe    <= '0;
         r_arg_valid <= 1'b0;
         r_arg_error <= 1'b0;
         r_tx_wr     <= 1'b0;
         if (w_echo) begin
            r_tx_wr   <= 1'b1;
            r_tx_data <= bus.Cmd;
         end
         if (w_abort) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: if (bus.NewCmd) begin
                  if (|w_decode) begin
                     r_strobe <= w_decode;
                     r_state  <= EXEC;
                  end else if (bus.Cmd == ASC_V) begin
                     r_state <= ARG;
                  end else if (bus.Cmd == ASC_A) begin
                     r_ch    <= '0;
                     r_state <= STAT;
                  end else begin
                     r_state <= ERR;
                  end
               end
               // EXEC/ARG_DONE already send '*' when a slot is free; ACK only holds it.
               EXEC, ARG_DONE, ACK: begin
                  if (w_slot) begin
                     r_tx_wr   <= 1'b1;
                     r_tx_data <= ASC_STAR;
                     r_state   <= IDLE;
                  end else begin
                     r_state <= ACK;
                  end
               end
               ERR: if (w_slot) begin
                  r_tx_wr   <= 1'b1;
                  r_tx_data <= ASC_BANG;
                  r_state   <= IDLE;
               end
               ARG: begin
                  if (w_arg_bad || w_arg_timeout) begin
                     r_arg_error <= 1'b1;
                     r_state     <= ERR;
                  end else if (w_arg_done) begin
                     r_arg_value <= w_arg_word;
                     r_arg_valid <= 1'b1;
                     r_state     <= ARG_DONE;
                  end
               end
               STAT: if (w_slot) begin
                  r_tx_wr   <= 1'b1;
                  r_tx_data <= ASC_0 + {4'h0, w_nibble};
                  if (r_ch == CH_W'(STAT_CH - 1)) r_state <= IDLE;
                  else                            r_ch    <= r_ch + 1'b1;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.cmdStrobe = r_strobe;
   assign bus.argValue  = r_arg_value;
   assign bus.argValid  = r_arg_valid;
   assign bus.argError  = r_arg_error;
   assign bus.txData    = r_tx_data;
   assign bus.txDataWr  = r_tx_wr;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Scoreboard bench for uart_cmd_sequencer: directed cases plus randomized
// command traffic against a character-level reference model.
module tb_uart_cmd_sequencer;
   localparam int unsigned ARG_BITS    = 10;
   localparam int unsigned STAT_CH     = 3;
   localparam int unsigned TIMEOUT_CYC = 100;
   localparam int unsigned SW          = 4 * STAT_CH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   t_cmd = 0;
   int   t_last = 0;
   int   last_stb = -1, last_wr = -1, last_valid = -1, last_err = -1;
   bit   rand_rdy = 1'b0;

   logic [7:0]          tx_q[$];
   logic [12:0]         stb_q[$];
   logic [ARG_BITS-1:0] argv_q[$];
   int                  err_q[$];

   bit                  m_in_arg = 1'b0;
   int                  m_acc = 0;
   int                  m_n = 0;
   logic [ARG_BITS-1:0] m_arg = '0;
   string               cmds = "DdCEeOoSTtUWX";
   string               unk  = "QZbq?";

   uart_cmd_sequencer_if #(.ARG_BITS(ARG_BITS), .STAT_CH(STAT_CH)) bus ();

   uart_cmd_sequencer #(
      .ARG_BITS    (ARG_BITS),
      .STAT_CH     (STAT_CH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: one received character in, expected responses queued.
   task automatic model_char(input logic [7:0] c, input bit echo_now);
      int idx;
      if (echo_now) tx_q.push_back(c);
      if (c == "R") begin
         m_in_arg = 1'b0;
         return;
      end
      if (m_in_arg) begin
         if (c == "0" || c == "1") begin
            m_acc = m_acc * 2 + ((c == "1") ? 1 : 0);
            m_n++;
            if (m_n == ARG_BITS) begin
               m_arg = ARG_BITS'(m_acc);
               argv_q.push_back(m_arg);
               tx_q.push_back("*");
               m_in_arg = 1'b0;
            end
         end else begin
            err_q.push_back(1);
            tx_q.push_back("!");
            m_in_arg = 1'b0;
         end
         return;
      end
      idx = -1;
      for (int i = 0; i < cmds.len(); i++) if (cmds[i] == c) idx = i;
      if (idx >= 0) begin
         stb_q.push_back(13'(1) << idx);
         tx_q.push_back("*");
      end else if (c == "V") begin
         m_in_arg = 1'b1;
         m_acc = 0;
         m_n = 0;
      end else if (c == "A") begin
         for (int k = 0; k < STAT_CH; k++)
            tx_q.push_back(8'h30 + 8'((bus.status >> (4 * k)) & 4'hF));
      end else begin
         tx_q.push_back("!");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.NewCmd = 1'b0;
         if (rand_rdy) bus.txReady = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic send_char(input logic [7:0] c, input bit use_model);
      @(posedge clk);
      #1;
      if (rand_rdy) bus.txReady = ($urandom_range(0, 3) != 0);
      bus.Cmd = c;
      bus.NewCmd = 1'b1;
      t_cmd = cyc;
      if (use_model) model_char(c, bus.echoChar && bus.txReady);
   endtask

   task automatic send_seq(input string s, input int gap);
      for (int i = 0; i < s.len(); i++) begin
         send_char(s[i], 1'b1);
         idle(gap);
      end
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      idle(1);
      while ((tx_q.size() + stb_q.size() + argv_q.size() + err_q.size()) != 0 && n < max_cyc) begin
         idle(1);
         n++;
      end
      check("drain", tx_q.size() + stb_q.size() + argv_q.size() + err_q.size(), 0);
      tx_q.delete();
      stb_q.delete();
      argv_q.delete();
      err_q.delete();
      idle(3);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.txDataWr) begin
            last_wr = cyc;
            check("tx_pending", tx_q.size() != 0, 1);
            if (tx_q.size() != 0) check("txData", bus.txData, tx_q.pop_front());
         end
         if (bus.cmdStrobe != '0) begin
            last_stb = cyc;
            check("strobe_pending", stb_q.size() != 0, 1);
            if (stb_q.size() != 0) check("cmdStrobe", bus.cmdStrobe, stb_q.pop_front());
         end
         if (bus.argValid) begin
            last_valid = cyc;
            check("argValid_pending", argv_q.size() != 0, 1);
            if (argv_q.size() != 0) check("argValue", bus.argValue, argv_q.pop_front());
         end
         if (bus.argError) begin
            last_err = cyc;
            check("argError_pending", err_q.size() != 0, 1);
            if (err_q.size() != 0) void'(err_q.pop_front());
            check("argValue_on_error", bus.argValue, m_arg);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] c;
      int kind, nb;
      bus.Cmd = '0;
      bus.NewCmd = 1'b0;
      bus.echoChar = 1'b0;
      bus.status = '0;
      bus.txReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmdStrobe", bus.cmdStrobe, 0);
      check("rst_argValue", bus.argValue, 0);
      check("rst_argValid", bus.argValid, 0);
      check("rst_argError", bus.argError, 0);
      check("rst_txData", bus.txData, 0);
      check("rst_txDataWr", bus.txDataWr, 0);
      rst = 1'b0;
      idle(2);

      // 'T': strobe one cycle after the character, '*' one cycle later
      send_char("T", 1'b1);
      wait_idle(50);
      check("T_strobe_latency", last_stb - t_cmd, 1);
      check("T_ack_latency", last_wr - t_cmd, 2);

      // Full argument, back-to-back bits
      send_char("V", 1'b1);
      send_seq("1011001110", 0);
      t_last = t_cmd;
      wait_idle(50);
      check("argValid_latency", last_valid - t_last, 1);
      check("arg_ack_latency", last_wr - t_last, 2);
      check("argValue_2CE", bus.argValue, 10'h2CE);

      // Bad fifth character
      send_char("V", 1'b1);
      send_seq("1011", 1);
      send_char("2", 1'b1);
      wait_idle(50);
      check("argValue_after_bad", bus.argValue, 10'h2CE);

      // Timeout after three bits
      send_char("V", 1'b1);
      send_seq("101", 1);
      t_last = t_cmd;
      err_q.push_back(1);
      tx_q.push_back("!");
      m_in_arg = 1'b0;
      wait_idle(300);
      check("timeout_latency", last_err - t_last, 100);

      // Status readout stalled by txReady low for 4 cycles
      bus.status = 12'h5A3;
      send_char("A", 1'b1);
      idle(2);
      bus.txReady = 1'b0;
      idle(4);
      bus.txReady = 1'b1;
      wait_idle(50);

      // Echo of 'E', then strobe and '*'
      bus.echoChar = 1'b1;
      send_char("E", 1'b1);
      wait_idle(50);
      check("E_strobe_latency", last_stb - t_cmd, 1);
      check("E_ack_latency", last_wr - t_cmd, 2);

      // 'D' arriving while '*' is held: echoed, no strobe, '*' afterwards
      bus.txReady = 1'b0;
      send_char("E", 1'b0);
      stb_q.push_back(13'(1) << 3);
      idle(3);
      send_char("D", 1'b0);
      bus.txReady = 1'b1;
      tx_q.push_back("D");
      tx_q.push_back("*");
      wait_idle(50);
      bus.echoChar = 1'b0;

      // 'R' while '*' is pending in ACK
      bus.txReady = 1'b0;
      send_char("S", 1'b0);
      stb_q.push_back(13'(1) << 7);
      idle(3);
      send_char("R", 1'b1);
      idle(1);
      bus.txReady = 1'b1;
      idle(5);
      wait_idle(50);
      send_char("T", 1'b1);
      wait_idle(50);

      // 'R' mid-argument, then an unknown command
      send_char("V", 1'b1);
      send_seq("1101", 1);
      send_char("R", 1'b1);
      wait_idle(50);
      check("argValue_after_abort", bus.argValue, 10'h2CE);
      send_char("Q", 1'b1);
      wait_idle(50);

      // Reset mid-STAT
      bus.txReady = 1'b0;
      bus.status = 12'h5A3;
      send_char("A", 1'b0);
      idle(3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midstat_cmdStrobe", bus.cmdStrobe, 0);
      check("midstat_argValue", bus.argValue, 0);
      check("midstat_argValid", bus.argValid, 0);
      check("midstat_argError", bus.argError, 0);
      check("midstat_txData", bus.txData, 0);
      check("midstat_txDataWr", bus.txDataWr, 0);
      m_arg = '0;
      m_in_arg = 1'b0;
      idle(2);
      rst = 1'b0;
      bus.txReady = 1'b1;
      idle(10);
      wait_idle(10);

      // Randomized traffic with random echo and txReady
      rand_rdy = 1'b1;
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 9);
         bus.echoChar = ($urandom_range(0, 1) != 0);
         case (kind)
            0, 1, 2, 3: send_char(cmds[$urandom_range(0, 12)], 1'b1);
            4, 5: begin
               send_char("V", 1'b1);
               for (int i = 0; i < ARG_BITS; i++) begin
                  c = ($urandom_range(0, 1) != 0) ? "1" : "0";
                  if ($urandom_range(0, 19) == 0) c = "x";
                  idle($urandom_range(0, 2));
                  send_char(c, 1'b1);
                  if (c == "x") break;
               end
            end
            6: begin
               bus.status = SW'($urandom);
               send_char("A", 1'b1);
            end
            7: send_char(unk[$urandom_range(0, 4)], 1'b1);
            8: send_char("R", 1'b1);
            default: begin
               send_char("V", 1'b1);
               nb = $urandom_range(1, ARG_BITS - 1);
               for (int i = 0; i < nb; i++) begin
                  idle($urandom_range(0, 2));
                  send_char(($urandom_range(0, 1) != 0) ? "1" : "0", 1'b1);
               end
               send_char("R", 1'b1);
            end
         endcase
         wait_idle(400);
      end
      rand_rdy = 1'b0;
      bus.txReady = 1'b1;
      bus.echoChar = 1'b0;
      idle(5);
      check("final_argValue", bus.argValue, m_arg);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
